mac_array_seq: RTL and testbench

//  Sequencer for the reconfigurable WS/OS MAC array (rows of mac_row, each a chain of mac_tile).

---
 rtl/mac_array_seq.sv | 196 +++++++++++++++++++
 tb/tb_mac_array_seq.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_array_seq.sv
// Pass sequencer for the WS/OS MAC array.
// One start pulse runs a full tile pass: weight load, execute and flush in WS mode,
// or execute, flush, toggle and drain in OS mode. Every output is a register; the
// pop decision for a cycle is taken at the clock edge that opens it, using the FIFO
// status sampled at that edge, so inst_w and the strobes always move together.
module mac_array_seq #(
    parameter int row    = 8,
    parameter int col    = 8,
    parameter int cnt_bw = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [cnt_bw-1:0] len,
    input  logic              l0_empty,
    input  logic              ififo_empty,
    input  logic              ofifo_full,
    output logic [1:0]        inst_w,
    output logic              l0_rd,
    output logic              ififo_rd,
    output logic              toggle,
    output logic              os_rd,
    output logic              busy,
    output logic              done
);

    localparam logic [cnt_bw-1:0] LOAD_N  = cnt_bw'(col);
    localparam logic [cnt_bw-1:0] FLUSH_N = cnt_bw'(row + col - 1);
    localparam logic [cnt_bw-1:0] DRAIN_N = cnt_bw'(row);

    typedef enum logic [2:0] {
        IDLE, WLOAD, EXEC, FLUSH, TOGGLE, DRAIN, DONE
    } state_t;

    state_t            state, state_n;
    logic [cnt_bw-1:0] cnt, cnt_n, cnt_inc, len_q;
    logic              mode_q, go, accept;
    logic [1:0]        inst_w_n;
    logic              l0_rd_n, ififo_rd_n, toggle_n, os_rd_n, busy_n, done_n;

    // cnt never exceeds target-1 before the increment, so cnt_inc cannot wrap
    assign cnt_inc = cnt + cnt_bw'(1);
    // done is still high in the cycle after DONE, which masks a start issued there
    assign accept  = (state == IDLE) && start && !done;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    // Per-state "go": every blocker must be clear for a pop or drain beat
    always_comb begin
        go = 1'b0;
        case (state)
            WLOAD:   go = !l0_empty;
            EXEC:    go = (len_q != '0) && !l0_empty && !ofifo_full && (!mode_q || !ififo_empty);
            DRAIN:   go = !ofifo_full;
            default: go = 1'b0;
        endcase
    end

    // Next-state and counter update; counters restart from zero on every state entry
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n = mode ? EXEC : WLOAD;
                    cnt_n   = '0;
                end
            end
            WLOAD: begin
                if (go) begin
                    if (cnt_inc == LOAD_N) begin
                        state_n = EXEC;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
            end
            EXEC: begin
                if (len_q == '0) begin
                    state_n = FLUSH;
                    cnt_n   = '0;
                end else if (go) begin
                    if (cnt_inc == len_q) begin
                        state_n = FLUSH;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
            end
            FLUSH: begin
                if (cnt_inc == FLUSH_N) begin
                    state_n = mode_q ? TOGGLE : DONE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            TOGGLE: begin
                state_n = DRAIN;
                cnt_n   = '0;
            end
            DRAIN: begin
                if (go) begin
                    if (cnt_inc == DRAIN_N) begin
                        state_n = DONE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Output values for the cycle that the coming edge opens
    always_comb begin
        inst_w_n   = 2'b00;
        l0_rd_n    = 1'b0;
        ififo_rd_n = 1'b0;
        toggle_n   = 1'b0;
        os_rd_n    = 1'b0;
        busy_n     = (state_n != IDLE) || (state == DONE);
        done_n     = (state == DONE);
        case (state)
            WLOAD: begin
                if (go) begin
                    l0_rd_n  = 1'b1;
                    inst_w_n = 2'b01;
                end
            end
            EXEC: begin
                if (go) begin
                    l0_rd_n    = 1'b1;
                    ififo_rd_n = mode_q;
                    inst_w_n   = 2'b10;
                end
            end
            TOGGLE:  toggle_n = 1'b1;
            DRAIN:   os_rd_n  = go;
            default: ;
        endcase
    end

    // Counter and latched pass configuration
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt    <= '0;
            mode_q <= 1'b0;
            len_q  <= '0;
        end else begin
            cnt <= cnt_n;
            if (accept) begin
                mode_q <= mode;
                len_q  <= len;
            end
        end
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            inst_w   <= 2'b00;
            l0_rd    <= 1'b0;
            ififo_rd <= 1'b0;
            toggle   <= 1'b0;
            os_rd    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            inst_w   <= inst_w_n;
            l0_rd    <= l0_rd_n;
            ififo_rd <= ififo_rd_n;
            toggle   <= toggle_n;
            os_rd    <= os_rd_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end

endmodule

// File: tb/tb_mac_array_seq.sv
// Self-checking bench for mac_array_seq: a phase-level reference model builds the
// expected per-cycle output trace of a pass from the stall pattern, and each scenario
// task also checks pass totals and latency against closed-form values.
module tb_mac_array_seq;

    localparam int ROW = 8;
    localparam int COL = 8;
    localparam int BW  = 8;
    localparam int NS  = 1024;

    logic          clk = 1'b0;
    logic          reset, start, mode;
    logic [BW-1:0] len;
    logic          l0_empty, ififo_empty, ofifo_full;
    logic [1:0]    inst_w;
    logic          l0_rd, ififo_rd, toggle, os_rd, busy, done;

    always #5 clk = ~clk;

    mac_array_seq #(.row(ROW), .col(COL), .cnt_bw(BW)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .len(len),
        .l0_empty(l0_empty), .ififo_empty(ififo_empty), .ofifo_full(ofifo_full),
        .inst_w(inst_w), .l0_rd(l0_rd), .ififo_rd(ififo_rd), .toggle(toggle),
        .os_rd(os_rd), .busy(busy), .done(done)
    );

    typedef struct packed {
        logic [1:0] inst;
        logic       l0, ifr, tog, os, bsy, dn;
    } obs_t;

    obs_t exp_q[$];
    // stimulus indexed by the clock edge that samples it (edge 0 samples start)
    bit s_l0e[NS], s_ife[NS], s_off[NS], s_start[NS];
    int n_checks = 0;
    int n_fail   = 0;
    int r_done, r_l0, r_if, r_tog, r_os, r_i01, r_i10;

    function automatic obs_t mk(logic [1:0] i, logic l, logic f, logic tg, logic o, logic b, logic d);
        obs_t x;
        x.inst = i; x.l0 = l; x.ifr = f; x.tog = tg; x.os = o; x.bsy = b; x.dn = d;
        return x;
    endfunction

    function automatic obs_t sample();
        return mk(inst_w, l0_rd, ififo_rd, toggle, os_rd, busy, done);
    endfunction

    // Expected trace: a busy setup cycle, then each phase as a list of beats/bubbles
    task automatic build_expected(input bit m, input int n);
        int t, k;
        exp_q.delete();
        exp_q.push_back(mk(2'b00, 0, 0, 0, 0, 1, 0));
        t = 1;
        if (!m) begin
            k = 0;
            while (k < COL) begin
                if (!s_l0e[t]) begin exp_q.push_back(mk(2'b01, 1, 0, 0, 0, 1, 0)); k++; end
                else exp_q.push_back(mk(2'b00, 0, 0, 0, 0, 1, 0));
                t++;
            end
        end
        if (n == 0) begin
            exp_q.push_back(mk(2'b00, 0, 0, 0, 0, 1, 0));
            t++;
        end else begin
            k = 0;
            while (k < n) begin
                if (!s_l0e[t] && !s_off[t] && (!m || !s_ife[t])) begin
                    exp_q.push_back(mk(2'b10, 1, m, 0, 0, 1, 0)); k++;
                end else exp_q.push_back(mk(2'b00, 0, 0, 0, 0, 1, 0));
                t++;
            end
        end
        for (int i = 0; i < ROW + COL - 1; i++) begin
            exp_q.push_back(mk(2'b00, 0, 0, 0, 0, 1, 0)); t++;
        end
        if (m) begin
            exp_q.push_back(mk(2'b00, 0, 0, 1, 0, 1, 0)); t++;
            k = 0;
            while (k < ROW) begin
                if (!s_off[t]) begin exp_q.push_back(mk(2'b00, 0, 0, 0, 1, 1, 0)); k++; end
                else exp_q.push_back(mk(2'b00, 0, 0, 0, 0, 1, 0));
                t++;
            end
        end
        exp_q.push_back(mk(2'b00, 0, 0, 0, 0, 1, 1));
        exp_q.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic fill_stim(input int pct, input bit stray);
        for (int i = 0; i < NS; i++) begin
            s_l0e[i]   = (i < 300) && ($urandom_range(99) < pct);
            s_ife[i]   = (i < 300) && ($urandom_range(99) < pct);
            s_off[i]   = (i < 300) && ($urandom_range(99) < pct);
            s_start[i] = stray && ($urandom_range(9) == 0);
        end
    endtask

    task automatic run_pass(input string name, input bit m, input int n);
        obs_t o;
        int   sz;
        build_expected(m, n);
        sz = exp_q.size();
        r_done = -1; r_l0 = 0; r_if = 0; r_tog = 0; r_os = 0; r_i01 = 0; r_i10 = 0;
        @(negedge clk);
        start = 1'b1; mode = m; len = BW'(n);
        l0_empty = s_l0e[0]; ififo_empty = s_ife[0]; ofifo_full = s_off[0];
        for (int t = 1; t <= sz; t++) begin
            @(negedge clk);
            o = sample();
            n_checks++;
            if (o !== exp_q[t-1]) begin
                n_fail++;
                $display("FAIL %s cycle %0d: got %b expected %b", name, t - 1, o, exp_q[t-1]);
            end
            if (o.l0 === 1'b1) r_l0++;
            if (o.ifr === 1'b1) r_if++;
            if (o.tog === 1'b1) r_tog++;
            if (o.os === 1'b1) r_os++;
            if (o.inst === 2'b01) r_i01++;
            if (o.inst === 2'b10) r_i10++;
            if (o.dn === 1'b1 && r_done < 0) r_done = t - 1;
            if (t < sz) begin
                start = s_start[t];
                mode = 1'($urandom); len = BW'($urandom);
                l0_empty = s_l0e[t]; ififo_empty = s_ife[t]; ofifo_full = s_off[t];
            end else begin
                start = 1'b0; l0_empty = 1'b0; ififo_empty = 1'b0; ofifo_full = 1'b0;
            end
        end
    endtask

    task automatic chk(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; mode = 1'b0; len = '0;
        l0_empty = 1'b0; ififo_empty = 1'b0; ofifo_full = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'(sample()), 0);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", int'(sample()), 0);
    endtask

    task automatic test_ws_basic();
        fill_stim(0, 0);
        run_pass("ws_len4", 0, 4);
        chk("ws_len4_done_cycle", r_done, 1 + COL + 4 + ROW + COL - 1);
        chk("ws_len4_load_cycles", r_i01, COL);
        chk("ws_len4_exec_cycles", r_i10, 4);
        chk("ws_len4_l0_pops", r_l0, 12);
    endtask

    task automatic test_os_basic();
        fill_stim(0, 0);
        run_pass("os_len3", 1, 3);
        chk("os_len3_done_cycle", r_done, 1 + 3 + ROW + COL - 1 + 1 + ROW);
        chk("os_len3_l0_pops", r_l0, 3);
        chk("os_len3_ififo_pops", r_if, 3);
        chk("os_len3_toggles", r_tog, 1);
        chk("os_len3_drain", r_os, ROW);
    endtask

    task automatic test_exec_stall();
        fill_stim(0, 0);
        s_l0e[11] = 1'b1; s_l0e[12] = 1'b1;
        run_pass("ws_exec_stall", 0, 6);
        chk("exec_stall_done_cycle", r_done, 1 + COL + 6 + ROW + COL - 1 + 2);
        chk("exec_stall_exec_cycles", r_i10, 6);
    endtask

    task automatic test_drain_stall();
        fill_stim(0, 0);
        s_off[21] = 1'b1; s_off[22] = 1'b1; s_off[23] = 1'b1;
        run_pass("os_drain_stall", 1, 3);
        chk("drain_stall_os_rd", r_os, ROW);
        chk("drain_stall_done_cycle", r_done, 1 + 3 + ROW + COL - 1 + 1 + ROW + 3);
    endtask

    task automatic test_len_zero();
        fill_stim(0, 1);
        run_pass("ws_len0", 0, 0);
        chk("ws_len0_done_cycle", r_done, 1 + COL + 1 + ROW + COL - 1);
        chk("ws_len0_exec_pops", r_i10, 0);
        fill_stim(0, 1);
        run_pass("os_len0", 1, 0);
        chk("os_len0_done_cycle", r_done, 1 + 1 + ROW + COL - 1 + 1 + ROW);
        chk("os_len0_l0_pops", r_l0, 0);
    endtask

    task automatic test_reset_mid_pass();
        int seen;
        fill_stim(0, 0);
        @(negedge clk);
        start = 1'b1; mode = 1'b0; len = BW'(6);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("midpass_reset_outputs", int'(sample()), 0);
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) seen++;
        end
        chk("midpass_reset_no_done", seen, 0);
        run_pass("after_reset_pass", 0, 2);
        chk("after_reset_done_cycle", r_done, 1 + COL + 2 + ROW + COL - 1);
    endtask

    task automatic test_random();
        bit m;
        int n;
        for (int i = 0; i < 12; i++) begin
            m = 1'($urandom);
            n = $urandom_range(20);
            fill_stim(25, 1);
            run_pass("random", m, n);
            chk("random_l0_pops", r_l0, m ? n : COL + n);
            chk("random_ififo_pops", r_if, m ? n : 0);
            chk("random_os_rd", r_os, m ? ROW : 0);
        end
    endtask

    task automatic test_len_max();
        fill_stim(0, 0);
        run_pass("os_len_max", 1, (1 << BW) - 1);
        chk("len_max_done_cycle", r_done, 1 + ((1 << BW) - 1) + ROW + COL - 1 + 1 + ROW);
        chk("len_max_l0_pops", r_l0, (1 << BW) - 1);
    endtask

    initial begin
        test_reset();
        test_ws_basic();
        test_os_basic();
        test_exec_stall();
        test_drain_stall();
        test_len_zero();
        test_reset_mid_pass();
        test_random();
        test_len_max();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
